// File: rtl/cpu_8b_serial_pkg.sv
// Shared definitions for the CPU_8B serial link (receiver now, transmitter later).
// Contents: frame geometry, line-level constants, receiver FSM state encoding and
// an even-parity helper.
// Optional feature macro: CPU_8B_SERIAL_RX_PARITY_EN adds the PARITY state (8E1 frames).
package cpu_8b_serial_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        LINE_IDLE  = 1'b1;
    localparam logic        LINE_STOP  = 1'b1;
    localparam logic        LINE_START = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef CPU_8B_SERIAL_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } serial_state_e;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/cpu_8b_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports: clock (rising edge), clear (async active-high, loads RESET_VAL),
//        d (asynchronous input), q (synchronized output).
module cpu_8b_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic clear,
    input  logic d,
    output logic q
);

    logic meta;

    // Resets to RESET_VAL so an idle-high line does not look like a start bit.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cpu_8b_serial_rx.sv
// Serial receiver for the CPU_8B serial output line: recovers 8N1 frames
// (8E1 when CPU_8B_SERIAL_RX_PARITY_EN is defined) and presents each byte
// through a valid/ready holding register.
// Ports:
//   clock               rising-edge clock
//   input_clear         async active-high reset
//   input_serial_in     asynchronous serial line, idle high
//   input_ready         consumer accepts output_data while output_valid is high
//   output_data         received byte, stable while output_valid
//   output_valid        holding register full
//   output_frame_error  one-cycle pulse: bad stop bit (or parity mismatch)
//   output_overrun      one-cycle pulse: good frame dropped, register full and not drained
module cpu_8b_serial_rx
    import cpu_8b_serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                 clock,
    input  logic                 input_clear,
    input  logic                 input_serial_in,
    input  logic                 input_ready,
    output logic [DATA_BITS-1:0] output_data,
    output logic                 output_valid,
    output logic                 output_frame_error,
    output logic                 output_overrun
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW   = $clog2(DATA_BITS);

    // Counter value seen on the edge that is HALF / CLKS_PER_BIT edges after the last wrap.
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic rx_s;

    serial_state_e        state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 frame_ok;

    cpu_8b_sync2 #(
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .clock (clock),
        .clear (input_clear),
        .d     (input_serial_in),
        .q     (rx_s)
    );

`ifdef CPU_8B_SERIAL_RX_PARITY_EN
    logic perr_q, perr_d;
    assign frame_ok = (rx_s == LINE_STOP) && !perr_q;
`else
    assign frame_ok = (rx_s == LINE_STOP);
`endif

    // Next-state: framing FSM, bit timing, shift register and holding register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q && !input_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef CPU_8B_SERIAL_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rx_s == LINE_START) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
`ifdef CPU_8B_SERIAL_RX_PARITY_EN
                    perr_d = 1'b0;
`endif
                    // A start bit gone high again by mid-bit is a glitch.
                    state_d = (rx_s == LINE_START) ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) begin
`ifdef CPU_8B_SERIAL_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef CPU_8B_SERIAL_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    perr_d  = (rx_s != even_parity(shift_q));
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    // Back to IDLE at the stop midpoint so a following start bit is caught.
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (!frame_ok) begin
                        ferr_d = 1'b1;
                    end else if (!valid_q || input_ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge input_clear) begin
        if (input_clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef CPU_8B_SERIAL_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef CPU_8B_SERIAL_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign output_data        = data_q;
    assign output_valid       = valid_q;
    assign output_frame_error = ferr_q;
    assign output_overrun     = ovr_q;

endmodule

// File: tb/tb_cpu_8b_serial_rx.sv
// Self-checking bench for cpu_8b_serial_rx: table-driven frames, hand-written
// overrun / glitch / clear sequences and a randomized phase, all cross-checked
// every cycle against a transaction-level model of the holding register.
module tb_cpu_8b_serial_rx;

    localparam int C    = 8;
    localparam int HALF = C / 2;
`ifdef CPU_8B_SERIAL_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // Frame length in clocks, and edges from the edge before the start bit is
    // driven to the edge where the frame's result becomes visible.
    localparam int FRAME = 10 * C + (PAR_EN ? C : 0);
    localparam int LAT   = 3 + HALF + 9 * C + (PAR_EN ? C : 0);

    logic       clock           = 1'b0;
    logic       input_clear     = 1'b1;
    logic       input_serial_in = 1'b1;
    logic       input_ready     = 1'b0;
    logic [7:0] output_data;
    logic       output_valid;
    logic       output_frame_error;
    logic       output_overrun;

    always #5 clock = ~clock;

    cpu_8b_serial_rx #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clock              (clock),
        .input_clear        (input_clear),
        .input_serial_in    (input_serial_in),
        .input_ready        (input_ready),
        .output_data        (output_data),
        .output_valid       (output_valid),
        .output_frame_error (output_frame_error),
        .output_overrun     (output_overrun)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         edge_no;
        logic [7:0] data;
        bit         good;
    } evt_t;

    evt_t q[$];
    int   cyc = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_fe    = 1'b0;
    logic       m_ov    = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Each frame completes at a known edge; apply the delivery/handshake rules there.
    initial forever begin : model
        evt_t ev;
        logic old_v;
        logic load;
        @(posedge clock or posedge input_clear);
        if (input_clear) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_fe    = 1'b0;
            m_ov    = 1'b0;
            q.delete();
        end else begin
            old_v = m_valid;
            load  = 1'b0;
            m_fe  = 1'b0;
            m_ov  = 1'b0;
            if (q.size() > 0 && q[0].edge_no == cyc + 1) begin
                ev = q.pop_front();
                if (!ev.good) m_fe = 1'b1;
                else if (!old_v || input_ready) begin
                    m_data  = ev.data;
                    m_valid = 1'b1;
                    load    = 1'b1;
                end else m_ov = 1'b1;
            end
            if (!load && old_v && input_ready) m_valid = 1'b0;
        end
    end

    always @(negedge clock) begin
        check("m_valid", 32'(output_valid), 32'(m_valid));
        check("m_data", 32'(output_data), 32'(m_data));
        check("m_ferr", 32'(output_frame_error), 32'(m_fe));
        check("m_ovr", 32'(output_overrun), 32'(m_ov));
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Called just after an edge; returns just after an edge.
    task automatic drive_frame(input logic [7:0] d, input bit stop_v, input bit par_flip);
        evt_t ev;
        ev.edge_no = cyc + LAT;
        ev.data    = d;
        ev.good    = stop_v && !(PAR_EN && par_flip);
        q.push_back(ev);
        input_serial_in = 1'b0;
        idle(C);
        for (int i = 0; i < 8; i++) begin
            input_serial_in = d[i];
            idle(C);
        end
        if (PAR_EN) begin
            input_serial_in = (^d) ^ par_flip;
            idle(C);
        end
        input_serial_in = stop_v;
        idle(C);
        input_serial_in = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_v;
        bit         par_flip;
        logic [7:0] exp_data;
        bit         exp_valid;
        bit         exp_fe;
    } vec_t;

    task automatic run_vec(input vec_t v);
        fork
            drive_frame(v.data, v.stop_v, v.par_flip);
            begin
                repeat (LAT - 1) @(posedge clock);
                @(negedge clock);
                check("early_valid", 32'(output_valid), 32'(0));
                check("early_ferr", 32'(output_frame_error), 32'(0));
                @(posedge clock);
                @(negedge clock);
                check("valid", 32'(output_valid), 32'(v.exp_valid));
                check("data", 32'(output_data), 32'(v.exp_data));
                check("ferr", 32'(output_frame_error), 32'(v.exp_fe));
                check("ovr", 32'(output_overrun), 32'(0));
                @(posedge clock);
                @(negedge clock);
                check("valid_pulse", 32'(output_valid), 32'(0));
                check("ferr_pulse", 32'(output_frame_error), 32'(0));
            end
        join
        @(posedge clock);
        #1;
    endtask

    vec_t tbl[8];
    bit   rnd_done;

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[1] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        tbl[4] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0};
        tbl[5] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b1, 1'b0};
        tbl[6] = PAR_EN ? '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1}
                        : '{8'h07, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
        tbl[7] = '{8'h6E, 1'b1, 1'b0, 8'h6E, 1'b1, 1'b0};

        // Reset state.
        @(negedge clock);
        check("rst_valid", 32'(output_valid), 32'(0));
        check("rst_data", 32'(output_data), 32'(0));
        check("rst_ferr", 32'(output_frame_error), 32'(0));
        check("rst_ovr", 32'(output_overrun), 32'(0));
        idle(3);
        input_clear = 1'b0;
        input_ready = 1'b1;
        idle(2 * C);

        // Table-driven single frames, consumer always ready.
        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i]);
            idle(2 * C);
        end

        // Back-to-back frames into a stalled consumer: second one overruns.
        input_ready = 1'b0;
        fork
            begin
                drive_frame(8'h3C, 1'b1, 1'b0);
                drive_frame(8'hC3, 1'b1, 1'b0);
            end
            begin
                repeat (LAT) @(posedge clock);
                @(negedge clock);
                check("ovr_first_valid", 32'(output_valid), 32'(1));
                check("ovr_first_data", 32'(output_data), 32'(8'h3C));
                repeat (FRAME) @(posedge clock);
                @(negedge clock);
                check("ovr_pulse", 32'(output_overrun), 32'(1));
                check("ovr_hold_data", 32'(output_data), 32'(8'h3C));
                check("ovr_hold_valid", 32'(output_valid), 32'(1));
                @(posedge clock);
                @(negedge clock);
                check("ovr_pulse_end", 32'(output_overrun), 32'(0));
                check("ovr_still_valid", 32'(output_valid), 32'(1));
            end
        join
        @(posedge clock);
        #1;
        input_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("drain_valid", 32'(output_valid), 32'(0));
        idle(2 * C);

        // Three-cycle low glitch, then a frame soon after it.
        input_serial_in = 1'b0;
        idle(3);
        input_serial_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("glitch_valid", 32'(output_valid), 32'(0));
            check("glitch_ferr", 32'(output_frame_error), 32'(0));
            @(posedge clock);
            #1;
        end
        run_vec('{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0});
        idle(2 * C);

        // Clear in the middle of a frame.
        fork
            drive_frame(8'hFF, 1'b1, 1'b0);
            begin
                idle(5 * C + HALF);
                input_clear = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    @(negedge clock);
                    check("clr_valid", 32'(output_valid), 32'(0));
                    check("clr_data", 32'(output_data), 32'(0));
                    check("clr_ferr", 32'(output_frame_error), 32'(0));
                    check("clr_ovr", 32'(output_overrun), 32'(0));
                    @(posedge clock);
                    #1;
                end
                input_clear = 1'b0;
            end
        join
        idle(2 * C);
        run_vec('{8'h12, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0});
        idle(2 * C);

        // Randomized frames and consumer stalls, checked by the model.
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    logic [7:0] d;
                    bit         sv;
                    bit         pf;
                    int         gap;
                    d  = 8'($urandom);
                    sv = ($urandom_range(0, 7) != 0);
                    pf = PAR_EN && ($urandom_range(0, 5) == 0);
                    drive_frame(d, sv, pf);
                    if (!sv) gap = 2 * C;
                    else gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2 * C));
                    if (gap > 0) idle(gap);
                end
                idle(4 * C);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clock);
                    #1;
                    input_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        input_ready = 1'b1;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
